// File: rtl/micro_ucr_pkg.sv
// Shared constants, state encoding and small helpers for the micro UCR miner.
// Pure declarations: no latency, no flow control.
package micro_ucr_pkg;

  localparam logic [7:0] H0_INIT = 8'h01;
  localparam logic [7:0] H1_INIT = 8'h89;
  localparam logic [7:0] H2_INIT = 8'hFE;

  localparam logic [7:0] K_LO = 8'h99;
  localparam logic [7:0] K_HI = 8'hA1;

  localparam int ROUNDS         = 32;
  localparam int K_SWITCH_ROUND = 16;

  localparam logic [4:0] ROUND_LAST = 5'(ROUNDS - 1);

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t LOAD  = 3'd1;
  localparam state_t ROUND = 3'd2;
  localparam state_t CHECK = 3'd3;
  localparam state_t DONE  = 3'd4;

  // Window holds W[j..j+15]; this yields W[j+16] = W[j+13] | (W[j+7] ^ W[j+2]).
  function automatic logic [7:0] sched_next(input logic [7:0] w13,
                                            input logic [7:0] w7,
                                            input logic [7:0] w2);
    return w13 | (w7 ^ w2);
  endfunction

  function automatic logic [23:0] finish_hash(input logic [7:0] a,
                                              input logic [7:0] b,
                                              input logic [7:0] c);
    logic [7:0] h0;
    logic [7:0] h1;
    logic [7:0] h2;
    h0 = H0_INIT + a;
    h1 = H1_INIT + b;
    h2 = H2_INIT + c;
    return {h0, h1, h2};
  endfunction

endpackage

// File: rtl/micro_ucr_round.sv
// One compression round: next a/b/c from current a/b/c, schedule word and round index.
// Purely combinational; no handshake.
module micro_ucr_round
  import micro_ucr_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  input  logic [7:0] w,
  input  logic [4:0] j,
  output logic [7:0] a_nxt,
  output logic [7:0] b_nxt,
  output logic [7:0] c_nxt
);

  logic       early;
  logic [7:0] k;
  logic [7:0] x;

  // Rounds 0..16 use the XOR mix with K_LO, the rest switch to OR with K_HI.
  assign early = (int'(j) <= K_SWITCH_ROUND);
  assign k     = early ? K_LO : K_HI;
  assign x     = early ? (a ^ b) : (a | b);

  assign a_nxt = b ^ c;
  assign b_nxt = {c[3:0], 4'h0};
  assign c_nxt = x + k + w;

endmodule

// File: rtl/micro_ucr_miner.sv
// Nonce search: per nonce LOAD(1) + ROUND(32) + CHECK(1) = 34 cycles, one-cycle DONE pulse.
// No backpressure: start is taken only in IDLE, stop aborts from LOAD/ROUND/CHECK.
module micro_ucr_miner
  import micro_ucr_pkg::*;
#(
  parameter logic [31:0] MAX_NONCE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [95:0] block_in,
  input  logic [7:0]  target,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] nonce_out,
  output logic [23:0] hash_out
);

  state_t           state;
  logic [95:0]      blk_q;
  logic [7:0]       tgt_q;
  logic [31:0]      nonce;
  logic [4:0]       rnd;
  logic [15:0][7:0] win;
  logic [7:0]       a;
  logic [7:0]       b;
  logic [7:0]       c;

  logic [7:0]       a_nxt;
  logic [7:0]       b_nxt;
  logic [7:0]       c_nxt;
  logic [23:0]      hash_now;
  logic             hit;
  logic             at_max;

  micro_ucr_round u_round (
    .a     (a),
    .b     (b),
    .c     (c),
    .w     (win[0]),
    .j     (rnd),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .c_nxt (c_nxt)
  );

  assign hash_now = finish_hash(a, b, c);
  assign hit      = (hash_now[23:16] < tgt_q) && (hash_now[15:8] < tgt_q);
  assign at_max   = (nonce == MAX_NONCE);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      blk_q     <= '0;
      tgt_q     <= '0;
      nonce     <= '0;
      rnd       <= '0;
      win       <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      found     <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            blk_q <= block_in;
            tgt_q <= target;
            nonce <= '0;
            state <= LOAD;
          end
        end

        LOAD: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            a   <= H0_INIT;
            b   <= H1_INIT;
            c   <= H2_INIT;
            rnd <= '0;
            for (int i = 0; i < 12; i++) begin
              win[i] <= blk_q[95 - 8*i -: 8];
            end
            win[12] <= nonce[31:24];
            win[13] <= nonce[23:16];
            win[14] <= nonce[15:8];
            win[15] <= nonce[7:0];
            state   <= ROUND;
          end
        end

        ROUND: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            a   <= a_nxt;
            b   <= b_nxt;
            c   <= c_nxt;
            win <= {sched_next(win[13], win[7], win[2]), win[15:1]};
            rnd <= rnd + 5'd1;
            if (rnd == ROUND_LAST) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          // stop outranks a same-cycle hit, so it is tested first.
          if (stop) begin
            state <= IDLE;
          end else if (hit || at_max) begin
            found     <= hit;
            nonce_out <= nonce;
            hash_out  <= hash_now;
            state     <= DONE;
          end else begin
            nonce <= nonce + 32'd1;
            state <= LOAD;
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_micro_ucr_miner.sv
// Directed bench for micro_ucr_miner (MAX_NONCE=3) against a reference hash model.
module tb_micro_ucr_miner;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [95:0] block_in;
  logic [7:0]  target;
  logic        busy;
  logic        done;
  logic        found;
  logic [31:0] nonce_out;
  logic [23:0] hash_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  micro_ucr_miner #(.MAX_NONCE(32'd3)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .block_in  (block_in),
    .target    (target),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .nonce_out (nonce_out),
    .hash_out  (hash_out)
  );

  function automatic logic [23:0] model_hash(input logic [95:0] blk, input logic [31:0] n);
    logic [7:0] w [32];
    logic [7:0] a, b, c, x, k, na, nb, nc, h0, h1, h2;
    for (int i = 0; i < 12; i++) w[i] = blk[95 - 8*i -: 8];
    w[12] = n[31:24];
    w[13] = n[23:16];
    w[14] = n[15:8];
    w[15] = n[7:0];
    for (int i = 16; i < 32; i++) w[i] = w[i-3] | (w[i-9] ^ w[i-14]);
    a = 8'h01; b = 8'h89; c = 8'hFE;
    for (int j = 0; j < 32; j++) begin
      if (j <= 16) begin k = 8'h99; x = a ^ b; end
      else         begin k = 8'hA1; x = a | b; end
      na = b ^ c;
      nb = c << 4;
      nc = x + k + w[j];
      a = na; b = nb; c = nc;
    end
    h0 = 8'h01 + a;
    h1 = 8'h89 + b;
    h2 = 8'hFE + c;
    return {h0, h1, h2};
  endfunction

  task automatic model_search(input logic [95:0] blk, input logic [7:0] tgt,
                              output logic f, output logic [31:0] n, output logic [23:0] h);
    f = 1'b0;
    n = 32'd3;
    h = model_hash(blk, 32'd3);
    for (int i = 0; i <= 3; i++) begin
      logic [23:0] t;
      t = model_hash(blk, i);
      if (t[23:16] < tgt && t[15:8] < tgt) begin
        f = 1'b1; n = i; h = t;
        break;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle 1 is the LOAD cycle right after the start edge; sampling is on the falling edge.
  task automatic run(input logic [95:0] blk, input logic [7:0] tgt, input int stop_at,
                     input int rst_at, input bit hold, input int max_cyc,
                     output int first_done, output int n_done, output logic [58:0] snap);
    int snap_at;
    @(negedge clk);
    block_in = blk;
    target   = tgt;
    start    = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    first_done = 0;
    n_done     = 0;
    snap       = '0;
    snap_at    = (stop_at > 0) ? stop_at + 1 : ((rst_at > 0) ? rst_at + 1 : 0);
    for (int cy = 1; cy <= max_cyc; cy++) begin
      if (done) begin
        n_done++;
        if (first_done == 0) first_done = cy;
      end
      if ((snap_at > 0 && cy == snap_at) ||
          (snap_at == 0 && first_done != 0 && cy == first_done + 1))
        snap = {busy, done, found, nonce_out, hash_out};
      if (hold && cy == 10) begin
        block_in = ~blk;
        target   = 8'h00;
      end
      if (hold && first_done != 0 && cy == first_done + 1) start = 1'b0;
      stop  = (cy == stop_at);
      reset = (cy == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    stop  = 1'b0;
    reset = 1'b1;
    start = 1'b0;
  endtask

  localparam logic [95:0] BLK_Z = 96'h0;
  localparam logic [95:0] BLK_A = 96'h0123_4567_89AB_CDEF_FEDC_BA98;
  localparam logic [95:0] BLK_B = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;

  initial begin
    int          fd, nd;
    logic [58:0] snap;
    logic        ef_a;
    logic [31:0] en_a;
    logic [23:0] eh_a;
    logic [23:0] eh_b3;

    reset = 1'b0; start = 1'b0; stop = 1'b0; block_in = '0; target = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_found", found, 0);
    chk("rst_nonce", nonce_out, 0);
    chk("rst_hash",  hash_out, 0);
    reset = 1'b1;

    // Zero block, nonce 0 hash worked by hand: C1 89 85.
    run(BLK_Z, 8'hFF, 0, 0, 0, 60, fd, nd, snap);
    chk("zero_found", found, 1);
    chk("zero_nonce", nonce_out, 0);
    chk("zero_hash_hand",  hash_out, 24'hC18985);
    chk("zero_hash_model", hash_out, model_hash(BLK_Z, 0));
    chk("zero_done_cyc", fd, 35);
    chk("zero_done_cnt", nd, 1);

    model_search(BLK_A, 8'hFF, ef_a, en_a, eh_a);
    run(BLK_A, 8'hFF, 0, 0, 0, 150, fd, nd, snap);
    chk("a_found", found, ef_a);
    chk("a_nonce", nonce_out, en_a);
    chk("a_hash",  hash_out, eh_a);
    chk("a_done_cyc", fd, 34 * (en_a + 1) + 1);
    chk("a_done_cnt", nd, 1);

    eh_b3 = model_hash(BLK_B, 3);
    run(BLK_B, 8'h00, 0, 0, 0, 150, fd, nd, snap);
    chk("max_done_cyc", fd, 137);
    chk("max_done_cnt", nd, 1);
    chk("max_found", found, 0);
    chk("max_nonce", nonce_out, 3);
    chk("max_hash",  hash_out, eh_b3);

    run(BLK_A, 8'hFF, 20, 0, 0, 60, fd, nd, snap);
    chk("stop_busy", snap[58], 0);
    chk("stop_done_cnt", nd, 0);
    chk("stop_found", found, 0);
    chk("stop_nonce", nonce_out, 3);
    chk("stop_hash",  hash_out, eh_b3);

    // Stop in CHECK of a nonce that would hit.
    run(BLK_Z, 8'hFF, 34, 0, 0, 60, fd, nd, snap);
    chk("stophit_busy", snap[58], 0);
    chk("stophit_done_cnt", nd, 0);
    chk("stophit_found", found, 0);
    chk("stophit_hash", hash_out, eh_b3);

    run(BLK_A, 8'hFF, 0, 10, 0, 40, fd, nd, snap);
    chk("mrst_busy",  snap[58], 0);
    chk("mrst_done",  snap[57], 0);
    chk("mrst_found", snap[56], 0);
    chk("mrst_nonce", snap[55:24], 0);
    chk("mrst_hash",  snap[23:0], 0);
    chk("mrst_done_cnt", nd, 0);

    run(BLK_Z, 8'hFF, 0, 0, 0, 60, fd, nd, snap);
    chk("post_rst_found", found, 1);
    chk("post_rst_hash",  hash_out, 24'hC18985);
    chk("post_rst_done_cyc", fd, 35);

    // Start held high, block and target changed mid-search.
    run(BLK_A, 8'hFF, 0, 0, 1, 160, fd, nd, snap);
    chk("hold_found", found, ef_a);
    chk("hold_nonce", nonce_out, en_a);
    chk("hold_hash",  hash_out, eh_a);
    chk("hold_done_cyc", fd, 34 * (en_a + 1) + 1);
    chk("hold_done_cnt", nd, 1);
    chk("hold_idle_after_done", snap[58], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
